uart_tx: RTL and testbench

//  Serial UART transmitter with a small input FIFO. Accepts N_BITS-wide words over a

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default link parameters and
// the frame-length helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 25 MHz system clock at 115200 baud, 8 data bits
  localparam int DEF_CLKS_PER_BIT = 217;
  localparam int DEF_N_BITS       = 8;

  // Total clk cycles occupied by one frame on the line
  function automatic int frame_cycles(input int clks_per_bit, input int n_bits,
                                      input int stop_bits);
    return (1 + n_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter. The full flag is a
// register so the upstream ready never has a combinational path from valid,
// and it is held high through reset so nothing is accepted until the FIFO is live.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; full follows next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers words in a small FIFO and serialises them as
// start / data (LSB first) / stop frames. The line, busy and done outputs are
// registered copies of the FSM, so the line trails the FSM by one cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int N_BITS       = DEF_N_BITS,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx_data,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(N_BITS) + 1;

  logic [1:0]        state;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     idx;
  logic [N_BITS-1:0] shift;
  logic [N_BITS-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              bit_end;
  logic              frame_end;

  assign ready = !fifo_full;

  uart_tx_fifo #(
    .WIDTH (N_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (valid),
    .push_data (data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Bit and frame boundaries; pop either from idle or at the very end of a frame
  always_comb begin
    bit_end   = (timer == TW'(CLKS_PER_BIT - 1));
    frame_end = (state == ST_STOP) && bit_end && (idx == IW'(STOP_BITS - 1));
    pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);
  end

  // Frame sequencer: timer counts cycles within a bit, idx counts data or stop bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift <= fifo_dout;
            timer <= '0;
            idx   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            timer <= '0;
            state <= ST_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            timer <= '0;
            shift <= {1'b0, shift[N_BITS-1:1]};
            if (idx == IW'(N_BITS - 1)) begin
              idx   <= '0;
              state <= ST_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            timer <= timer + IW'(0) + TW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (frame_end) begin
              idx <= '0;
              if (pop) begin
                shift <= fifo_dout;
                state <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered line and status outputs; the line idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_START: tx_data <= 1'b0;
        ST_DATA:  tx_data <= shift[0];
        default:  tx_data <= 1'b1;
      endcase
      busy <= (state != ST_IDLE);
      done <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a directed driver pushes hand-picked words
// into an expected-value queue, and a loopback receiver per DUT decodes each
// frame from the line and checks it against the head of that queue.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       valid0 = 1'b0;
  logic       valid1 = 1'b0;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         start_q0[$];
  int         start_q1[$];
  int         done_q0[$];
  int         done_q1[$];
  int         acc_q0[$];
  int         acc_q1[$];
  bit         in_frame[2];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .N_BITS(NB), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data(data0), .valid(valid0), .ready(ready0),
    .tx_data(tx0), .busy(busy0), .done(done0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .N_BITS(NB), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .data(data1), .valid(valid1), .ready(ready1),
    .tx_data(tx1), .busy(busy1), .done(done1)
  );

  // Edge counter: read right after a posedge it gives that edge's index
  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge at which each done pulse rose
  always @(negedge clk) begin
    if (done0 === 1'b1) done_q0.push_back(cyc - 1);
    if (done1 === 1'b1) done_q1.push_back(cyc - 1);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Loopback receiver: samples at every negedge, checks frame shape and done placement
  task automatic monitor(input int ch, input int stop_bits);
    int         total;
    int         bp;
    int         bad_shape;
    int         bad_done;
    bit         aborted;
    logic       v;
    logic       d;
    logic       b;
    logic [7:0] rx;
    logic [7:0] expv;
    total = (1 + NB + stop_bits) * CPB;
    forever begin
      @(negedge clk);
      if (!rst && (((ch == 0) ? tx0 : tx1) === 1'b0)) begin
        in_frame[ch] = 1'b1;
        if (ch == 0) start_q0.push_back(cyc - 1);
        else         start_q1.push_back(cyc - 1);
        bad_shape = 0;
        bad_done  = 0;
        aborted   = 1'b0;
        rx        = 8'h00;
        for (int j = 0; j < total; j++) begin
          if (j > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          v  = (ch == 0) ? tx0 : tx1;
          d  = (ch == 0) ? done0 : done1;
          b  = (ch == 0) ? busy0 : busy1;
          bp = j / CPB;
          if (bp == 0) begin
            if (v !== 1'b0) bad_shape++;
          end else if (bp <= NB) begin
            if (j % CPB == 0) rx[bp-1] = v;
            else if (v !== rx[bp-1]) bad_shape++;
          end else begin
            if (v !== 1'b1) bad_shape++;
          end
          if (b !== 1'b1) bad_shape++;
          if (d !== (j == total - 1)) bad_done++;
        end
        in_frame[ch] = 1'b0;
        if (!aborted) begin
          checkOutput($sformatf("ch%0d frame shape", ch), bad_shape, 0);
          checkOutput($sformatf("ch%0d done placement", ch), bad_done, 0);
          if (((ch == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ch%0d unexpected frame: got 0x%0h, expected no frame", ch, rx);
          end else begin
            expv = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput($sformatf("ch%0d rx byte", ch), int'(rx), int'(expv));
          end
        end
      end
    end
  endtask

  // Present one word at a negedge, hold until accepted, queue it as expected
  task automatic applyStimulus(input int ch, input logic [7:0] w);
    int   waitc;
    logic r;
    waitc = 0;
    if (ch == 0) begin data0 = w; valid0 = 1'b1; end
    else         begin data1 = w; valid1 = 1'b1; end
    r = (ch == 0) ? ready0 : ready1;
    while (r !== 1'b1 && waitc < 400) begin
      @(negedge clk);
      waitc++;
      r = (ch == 0) ? ready0 : ready1;
    end
    if (r !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ch%0d accept timeout: ready=%b, expected 1", ch, r);
    end else begin
      @(posedge clk);
      if (ch == 0) begin acc_q0.push_back(cyc); exp_q0.push_back(w); end
      else         begin acc_q1.push_back(cyc); exp_q1.push_back(w); end
      @(negedge clk);
    end
    if (ch == 0) begin valid0 = 1'b0; data0 = ~w; end
    else         begin valid1 = 1'b0; data1 = ~w; end
  endtask

  task automatic waitDrain(input int ch);
    int n;
    n = 0;
    while ((((ch == 0) ? exp_q0.size() : exp_q1.size()) != 0 || in_frame[ch]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ch%0d drain timeout: %0d words still queued, expected 0", ch,
               (ch == 0) ? exp_q0.size() : exp_q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      monitor(0, 1);
      monitor(1, 2);
    join_none
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad, s, dn, a;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ready during reset", ready0, 0);
    checkOutput("tx during reset", tx0, 1);
    checkOutput("busy during reset", busy0, 0);
    checkOutput("done during reset", done0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready after reset", ready0, 1);

    // Idle for 100 cycles
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || ready0 !== 1'b1) bad++;
    end
    checkOutput("idle 100 cycles", bad, 0);

    // Single word 0xA5
    s  = start_q0.size();
    dn = done_q0.size();
    applyStimulus(0, 8'hA5);
    waitDrain(0);
    checkOutput("A5 latency", start_q0[s] - acc_q0[acc_q0.size()-1], 2);
    checkOutput("A5 done count", done_q0.size() - dn, 1);
    checkOutput("A5 frame length", done_q0[dn] - start_q0[s] + 1, 40);

    // Three back-to-back words
    s  = start_q0.size();
    dn = done_q0.size();
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    applyStimulus(0, 8'h55);
    waitDrain(0);
    checkOutput("b2b gap 1", start_q0[s+1] - start_q0[s], 40);
    checkOutput("b2b gap 2", start_q0[s+2] - start_q0[s+1], 40);
    checkOutput("b2b done count", done_q0.size() - dn, 3);
    checkOutput("b2b span", done_q0[dn+2] - start_q0[s] + 1, 120);

    // Six words against a four-entry FIFO
    dn = done_q0.size();
    a  = acc_q0.size();
    for (int i = 1; i <= 6; i++) applyStimulus(0, 8'(i));
    waitDrain(0);
    checkOutput("5th accept before first done", int'(acc_q0[a+4] < done_q0[dn]), 1);
    checkOutput("6th accept not before first done", int'(acc_q0[a+5] >= done_q0[dn]), 1);
    checkOutput("full test done count", done_q0.size() - dn, 6);

    // Reset in the middle of data bit 3
    applyStimulus(0, 8'h3C);
    a = acc_q0[acc_q0.size()-1];
    applyStimulus(0, 8'h11);
    while (cyc < a + 19) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("tx after mid-frame reset", tx0, 1);
    checkOutput("done after mid-frame reset", done0, 0);
    checkOutput("busy after mid-frame reset", busy0, 0);
    checkOutput("ready during mid-frame reset", ready0, 0);
    #1 rst = 1'b0;
    exp_q0.delete();
    dn  = done_q0.size();
    s   = start_q0.size();
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    checkOutput("line quiet after reset", bad, 0);
    checkOutput("no frame after reset", start_q0.size() - s, 0);
    checkOutput("no done after reset", done_q0.size() - dn, 0);
    applyStimulus(0, 8'h81);
    waitDrain(0);
    checkOutput("post-reset done count", done_q0.size() - dn, 1);

    // Two stop bits
    s  = start_q1.size();
    dn = done_q1.size();
    applyStimulus(1, 8'hFF);
    waitDrain(1);
    checkOutput("2-stop latency", start_q1[s] - acc_q1[acc_q1.size()-1], 2);
    checkOutput("2-stop done count", done_q1.size() - dn, 1);
    checkOutput("2-stop frame length", done_q1[dn] - start_q1[s] + 1, 44);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
